vga_text_renderer: RTL and testbench

- Parametrised text-mode pixel pipeline between the VGA timing generator and the RGB pins.
- Converts the timing generator's (x, y, valid) stream into colour pixels.
- Reads a character/attribute word from an external text RAM, then a glyph row from an external font ROM.
- Serialises the glyph MSB-first with per-cell foreground/background colours and a blinking block cursor; syncs are delayed to match pixel latency.

---
 rtl/vga_text_pkg.sv | 22 ++
 rtl/vga_color_map.sv | 22 ++
 rtl/vga_text_renderer.sv | 150 +++++++++++++++
 tb/tb_vga_text_renderer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/vga_text_pkg.sv
// rtl/vga_text_pkg.sv - shared field offsets, colour-index bits and helpers for the text renderer
package vga_text_pkg;

  localparam int CHAR_LSB = 0;
  localparam int ATTR_LSB = 8;

  // colour index layout is {I,B,G,R}
  localparam int CI_R = 0;
  localparam int CI_G = 1;
  localparam int CI_B = 2;
  localparam int CI_I = 3;

  localparam int PIPE_LAT = 3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/vga_color_map.sv
// rtl/vga_color_map.sv - combinational {I,B,G,R} colour index to per-channel levels
module vga_color_map
  import vga_text_pkg::*;
#(
  parameter int COLOR_W = 4
) (
  input  logic [3:0]         idx,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b
);

  logic [COLOR_W-1:0] level;

  always_comb begin
    level = idx[CI_I] ? {COLOR_W{1'b1}} : {1'b0, {(COLOR_W-1){1'b1}}};
    r     = idx[CI_R] ? level : '0;
    g     = idx[CI_G] ? level : '0;
    b     = idx[CI_B] ? level : '0;
  end

endmodule

// File: rtl/vga_text_renderer.sv
// rtl/vga_text_renderer.sv - 3-stage text-mode pixel pipeline: text RAM, font ROM, colour, cursor, sync delay
module vga_text_renderer
  import vga_text_pkg::*;
#(
  parameter int   H_ACTIVE     = 640,
  parameter int   V_ACTIVE     = 480,
  parameter int   GLYPH_W      = 8,
  parameter int   GLYPH_H      = 8,
  parameter int   COLOR_W      = 4,
  parameter int   BLINK_FRAMES = 32,
  parameter logic SYNC_IDLE    = 1'b1,
  localparam int  COLS         = H_ACTIVE / GLYPH_W,
  localparam int  ROWS         = V_ACTIVE / GLYPH_H,
  localparam int  TA_W         = clog2(COLS * ROWS),
  localparam int  FA_W         = 8 + clog2(GLYPH_H)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               valid,
  input  logic               newframe,
  input  logic               hsync_in,
  input  logic               vsync_in,
  output logic [TA_W-1:0]    text_addr,
  input  logic [15:0]        text_data,
  output logic [FA_W-1:0]    font_addr,
  input  logic [GLYPH_W-1:0] font_data,
  input  logic               cursor_en,
  input  logic [7:0]         cursor_col,
  input  logic [7:0]         cursor_row,
  output logic [COLOR_W-1:0] R,
  output logic [COLOR_W-1:0] G,
  output logic [COLOR_W-1:0] B,
  output logic               hsync,
  output logic               vsync
);

  localparam int GW_SH = clog2(GLYPH_W);
  localparam int GH_SH = clog2(GLYPH_H);
  localparam int BC_W  = (BLINK_FRAMES > 1) ? clog2(BLINK_FRAMES) : 1;

  logic [9-GW_SH:0]   col;
  logic [9-GH_SH:0]   row;
  logic               hit_c;
  logic [GW_SH-1:0]   px0, px1, px_rev;
  logic [GH_SH-1:0]   gr0;
  logic               hit0, hit1, v0, v1;
  logic [7:0]         attr1;
  logic               pix_bit, swap;
  logic [3:0]         cidx;
  logic [COLOR_W-1:0] r_c, g_c, b_c;
  logic [PIPE_LAT-1:0] hs_d, vs_d;
  logic [BC_W-1:0]    blink_cnt;
  logic               blink_phase;

  // row*COLS as a sum of shifted copies, one per set bit of the constant
  function automatic logic [TA_W-1:0] row_base(input logic [9-GH_SH:0] r);
    logic [TA_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < 31; i++)
      if (COLS[i]) acc = acc + (TA_W'(r) << i);
    return acc;
  endfunction

  assign col   = x[9:GW_SH];
  assign row   = y[9:GH_SH];
  assign hit_c = cursor_en
              && (int'(cursor_col) < COLS) && (int'(cursor_row) < ROWS)
              && (int'(cursor_col) == int'(col)) && (int'(cursor_row) == int'(row));

  always_ff @(posedge clk) begin
    if (!rst) begin
      text_addr <= '0;
      px0       <= '0;
      gr0       <= '0;
      hit0      <= 1'b0;
      v0        <= 1'b0;
      font_addr <= '0;
      attr1     <= '0;
      px1       <= '0;
      hit1      <= 1'b0;
      v1        <= 1'b0;
    end else begin
      text_addr <= row_base(row) + TA_W'(col);
      px0       <= x[GW_SH-1:0];
      gr0       <= y[GH_SH-1:0];
      hit0      <= hit_c;
      v0        <= valid;
      font_addr <= {text_data[CHAR_LSB +: 8], gr0};
      attr1     <= text_data[ATTR_LSB +: 8];
      px1       <= px0;
      hit1      <= hit0;
      v1        <= v0;
    end
  end

  // GLYPH_W is a power of two, so GLYPH_W-1-px is just the inverted column
  assign px_rev  = ~px1;
  assign pix_bit = font_data[px_rev];
  assign swap    = hit1 && blink_phase;
  assign cidx    = (pix_bit ^ swap) ? attr1[3:0] : attr1[7:4];

  vga_color_map #(.COLOR_W(COLOR_W)) u_color_map (
    .idx (cidx),
    .r   (r_c),
    .g   (g_c),
    .b   (b_c)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      R <= '0;
      G <= '0;
      B <= '0;
    end else begin
      R <= v1 ? r_c : '0;
      G <= v1 ? g_c : '0;
      B <= v1 ? b_c : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hs_d <= {PIPE_LAT{SYNC_IDLE}};
      vs_d <= {PIPE_LAT{SYNC_IDLE}};
    end else begin
      hs_d <= {hs_d[PIPE_LAT-2:0], hsync_in};
      vs_d <= {vs_d[PIPE_LAT-2:0], vsync_in};
    end
  end

  assign hsync = hs_d[PIPE_LAT-1];
  assign vsync = vs_d[PIPE_LAT-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (newframe) begin
      if (blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_text_renderer.sv
// tb/tb_vga_text_renderer.sv - scoreboard bench for vga_text_renderer
module tb_vga_text_renderer;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  x, y;
  logic        valid, newframe, hsync_in, vsync_in;
  logic [12:0] text_addr;
  logic [15:0] text_data;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic        cursor_en;
  logic [7:0]  cursor_col, cursor_row;
  logic [3:0]  R, G, B;
  logic        hsync, vsync;

  logic [15:0] tram [0:8191];
  logic [7:0]  from [0:2047];

  assign text_data = tram[text_addr];
  assign font_data = from[font_addr];

  always #5 clk = ~clk;

  vga_text_renderer #(.BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .valid(valid), .newframe(newframe),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .text_addr(text_addr), .text_data(text_data),
    .font_addr(font_addr), .font_data(font_data),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .R(R), .G(G), .B(B), .hsync(hsync), .vsync(vsync)
  );

  typedef struct {
    int          due;
    int          kind;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic [12:0] addr;
  } ent_t;

  ent_t q[$];
  ent_t mon_e;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic        h_rst [3];
  logic [11:0] h_e   [3];
  logic        h_hs  [3];
  logic        h_vs  [3];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      mon_e = q.pop_front();
      total++;
      case (mon_e.kind)
        0: if ({R, G, B} !== mon_e.rgb || hsync !== mon_e.hs || vsync !== mon_e.vs) begin
             bad++;
             $display("FAIL pixel@%0d got rgb=%h hs=%b vs=%b want rgb=%h hs=%b vs=%b",
                      mon_e.due, {R, G, B}, hsync, vsync, mon_e.rgb, mon_e.hs, mon_e.vs);
           end
        1: if (text_addr !== mon_e.addr) begin
             bad++;
             $display("FAIL text_addr@%0d got %0d want %0d", mon_e.due, text_addr, mon_e.addr);
           end
        default: if ({2'b00, font_addr} !== mon_e.addr) begin
             bad++;
             $display("FAIL font_addr@%0d got %h want %h", mon_e.due, font_addr, mon_e.addr);
           end
      endcase
    end
  end

  // drive one cycle; expected output for the coming edge comes from the inputs two edges back
  task automatic step(input logic r, input int xx, input int yy, input logic vv,
                      input logic hs, input logic vs, input logic nf, input logic [11:0] e);
    ent_t ent;
    rst = r; x = 10'(xx); y = 10'(yy); valid = vv;
    hsync_in = hs; vsync_in = vs; newframe = nf;
    for (int k = 2; k > 0; k--) begin
      h_rst[k] = h_rst[k-1]; h_e[k] = h_e[k-1]; h_hs[k] = h_hs[k-1]; h_vs[k] = h_vs[k-1];
    end
    h_rst[0] = r; h_e[0] = e; h_hs[0] = hs; h_vs[0] = vs;
    ent.due = cyc + 1; ent.kind = 0; ent.addr = '0;
    if (!h_rst[0] || !h_rst[1] || !h_rst[2]) begin
      ent.rgb = 12'h000; ent.hs = 1'b1; ent.vs = 1'b1;
    end else begin
      ent.rgb = h_e[2]; ent.hs = h_hs[2]; ent.vs = h_vs[2];
    end
    q.push_back(ent);
    @(posedge clk); #1;
  endtask

  task automatic chk_addr(input int kind, input logic [12:0] a);
    ent_t ent;
    ent.due = cyc; ent.kind = kind; ent.rgb = '0; ent.hs = 1'b0; ent.vs = 1'b0; ent.addr = a;
    q.push_back(ent);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
  endtask

  // 'A' with attr 1F, font row 0 = 1000_0001: fg index F, bg index 1
  function automatic logic [11:0] pat_a(input int px, input logic sw);
    logic on;
    on = (px == 0 || px == 7) ^ sw;
    return on ? 12'hFFF : 12'h700;
  endfunction

  initial begin
    for (int i = 0; i < 8192; i++) tram[i] = 16'h1F41;
    tram[4799] = 16'h2C42;
    for (int i = 0; i < 2048; i++) from[i] = 8'h00;
    from[{8'h41, 3'd0}] = 8'b1000_0001;
    from[{8'h42, 3'd7}] = 8'b1010_0101;
    for (int k = 0; k < 3; k++) begin
      h_rst[k] = 1'b0; h_e[k] = '0; h_hs[k] = 1'b1; h_vs[k] = 1'b1;
    end
    rst = 1'b0; x = '0; y = '0; valid = 1'b0; newframe = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1;
    cursor_en = 1'b0; cursor_col = 8'd2; cursor_row = 8'd1;
    @(posedge clk); #1;

    // reset with toggling syncs, then release
    for (int i = 0; i < 4; i++) step(1'b0, 0, 0, 1'b0, i[0], ~i[0], 1'b1, 12'h000);
    for (int i = 0; i < 4; i++) step(1'b1, 0, 0, 1'b0, i[0], ~i[0], 1'b0, 12'h000);
    idle(2);

    // first glyph row of cell 0, hsync falling with the first pixel
    for (int px = 0; px < 8; px++) begin
      step(1'b1, px, 0, 1'b1, (px == 0) ? 1'b0 : 1'b1, 1'b1, 1'b0, pat_a(px, 1'b0));
      if (px == 0) chk_addr(1, 13'd0);
    end
    idle(3);

    // bottom-right cell and just past the visible area
    step(1'b1, 632, 479, 1'b1, 1'b1, 1'b1, 1'b0, 12'h00F);
    step(1'b1, 633, 479, 1'b1, 1'b1, 1'b1, 1'b0, 12'h070);
    step(1'b1, 639, 479, 1'b1, 1'b1, 1'b1, 1'b0, 12'h00F);
    chk_addr(1, 13'd4799);
    step(1'b1, 640, 479, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
    chk_addr(2, {2'b00, 8'h42, 3'd7});
    idle(3);

    // blinking cursor at (2,1): swapped after the 2nd and 3rd frame pulses
    cursor_en = 1'b1;
    for (int f = 0; f < 5; f++) begin
      for (int xx = 16; xx <= 24; xx++)
        step(1'b1, xx, 8, 1'b1, 1'b1, 1'b1, 1'b0,
             (xx == 24) ? 12'hFFF : pat_a(xx - 16, (f == 2 || f == 3)));
      idle(2);
      if (f < 4) step(1'b1, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000);
      idle(2);
    end
    cursor_en = 1'b0;

    // reset pulse mid-line with syncs active
    for (int xx = 296; xx <= 310; xx++)
      step((xx == 300) ? 1'b0 : 1'b1, xx, 0, 1'b1, 1'b0, 1'b0, 1'b0, pat_a(xx % 8, 1'b0));
    idle(4);

    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
